// File: rtl/uart_key_decoder.sv
// rtl/uart_key_decoder.sv - UART byte stream to 16-bit player instruction word
// Decodes plain keys and ANSI arrow escapes into held directions, pulses and menu selection.
module uart_key_decoder #(
  parameter int HOLD_TICKS  = 3,
  parameter int ESC_TIMEOUT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tick,
  output logic [15:0] instr,
  output logic        esc_pending
);

  typedef enum logic [1:0] {S_IDLE, S_ESC, S_CSI} state_t;

  localparam logic [7:0] HOLD_LD = 8'(HOLD_TICKS);
  localparam logic [7:0] ESC_LIM = 8'(ESC_TIMEOUT);

  state_t      r_state;
  logic [7:0]  r_timer;
  logic [7:0]  r_cnt [4];
  logic [15:0] r_instr;
  logic        r_esc_pending;

  state_t      w_state_nxt;
  logic [7:0]  w_timer_nxt;
  logic [7:0]  w_cnt_nxt [4];
  logic        w_plain;
  logic        w_timeout_cancel;
  logic [3:0]  w_csi_load;
  logic [3:0]  w_key_load;
  logic [3:0]  w_load;
  logic        w_confirm;
  logic        w_cancel;
  logic        w_menu_ld;
  logic [1:0]  w_menu_val;

  // Escape sequence tracking; a byte in the same cycle as a tick wins over the tick.
  always_comb begin
    w_state_nxt      = r_state;
    w_timer_nxt      = r_timer;
    w_plain          = 1'b0;
    w_timeout_cancel = 1'b0;
    w_csi_load       = 4'b0000;
    case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == 8'h1B) begin
            w_state_nxt = S_ESC;
            w_timer_nxt = 8'd0;
          end else begin
            w_plain = 1'b1;
          end
        end
      end
      S_ESC: begin
        if (rx_valid) begin
          if (rx_data == 8'h5B) begin
            w_state_nxt = S_CSI;
          end else if (rx_data == 8'h1B) begin
            w_timer_nxt = 8'd0;
          end else begin
            w_state_nxt = S_IDLE;
            w_plain     = 1'b1;
          end
        end else if (tick) begin
          if (r_timer == ESC_LIM - 8'd1) begin
            w_state_nxt      = S_IDLE;
            w_timer_nxt      = 8'd0;
            w_timeout_cancel = 1'b1;
          end else begin
            w_timer_nxt = r_timer + 8'd1;
          end
        end
      end
      S_CSI: begin
        if (rx_valid) begin
          w_state_nxt = S_IDLE;
          case (rx_data)
            8'h41:   w_csi_load = 4'b0001;
            8'h42:   w_csi_load = 4'b0010;
            8'h43:   w_csi_load = 4'b1000;
            8'h44:   w_csi_load = 4'b0100;
            default: w_csi_load = 4'b0000;
          endcase
        end else if (tick) begin
          if (r_timer == ESC_LIM - 8'd1) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = 8'd0;
          end else begin
            w_timer_nxt = r_timer + 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = 8'd0;
      end
    endcase
  end

  always_comb begin
    w_key_load = 4'b0000;
    w_confirm  = 1'b0;
    w_menu_ld  = 1'b0;
    w_menu_val = rx_data[1:0] - 2'd1;
    if (w_plain) begin
      case (rx_data)
        8'h77, 8'h57: w_key_load = 4'b0001;
        8'h73, 8'h53: w_key_load = 4'b0010;
        8'h61, 8'h41: w_key_load = 4'b0100;
        8'h64, 8'h44: w_key_load = 4'b1000;
        8'h20, 8'h0D: w_confirm  = 1'b1;
        8'h31, 8'h32, 8'h33, 8'h34: w_menu_ld = 1'b1;
        default: w_key_load = 4'b0000;
      endcase
    end
  end

  assign w_load   = w_key_load | w_csi_load;
  assign w_cancel = w_timeout_cancel | (w_plain & ((rx_data == 8'h78) | (rx_data == 8'h58)));

  // Index i^1 is the opposite direction on the same axis.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (w_load[i]) begin
        w_cnt_nxt[i] = HOLD_LD;
      end else if (w_load[i ^ 1]) begin
        w_cnt_nxt[i] = 8'd0;
      end else if (tick && (r_cnt[i] != 8'd0)) begin
        w_cnt_nxt[i] = r_cnt[i] - 8'd1;
      end else begin
        w_cnt_nxt[i] = r_cnt[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_timer       <= 8'd0;
      r_instr       <= 16'h0000;
      r_esc_pending <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= 8'd0;
      end
    end else begin
      r_state       <= w_state_nxt;
      r_timer       <= w_timer_nxt;
      r_esc_pending <= (w_state_nxt != S_IDLE);
      for (int i = 0; i < 4; i++) begin
        r_cnt[i]   <= w_cnt_nxt[i];
        r_instr[i] <= (w_cnt_nxt[i] != 8'd0);
      end
      r_instr[4] <= w_confirm;
      r_instr[5] <= w_cancel;
      if (w_menu_ld) begin
        r_instr[7:6] <= w_menu_val;
      end
      if (w_plain) begin
        r_instr[15:8] <= rx_data;
      end
    end
  end

  assign instr       = r_instr;
  assign esc_pending = r_esc_pending;

endmodule

// File: tb/tb_uart_key_decoder.sv
// tb/tb_uart_key_decoder.sv - directed self-checking bench for uart_key_decoder
// Inputs change on the falling edge; outputs are checked on the following falling edge.
module tb_uart_key_decoder;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tick;
  logic [15:0] instr;
  logic        esc_pending;

  int tests;
  int fails;

  uart_key_decoder #(.HOLD_TICKS(3), .ESC_TIMEOUT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tick       (tick),
    .instr      (instr),
    .esc_pending(esc_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic v, input logic [7:0] d, input logic t);
    rx_valid = v;
    rx_data  = d;
    tick     = t;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [15:0] exp_i, input logic exp_p);
    tests++;
    if (instr !== exp_i || esc_pending !== exp_p) begin
      fails++;
      $display("FAIL %s: instr=%h esc_pending=%b, expected instr=%h esc_pending=%b",
               name, instr, esc_pending, exp_i, exp_p);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (instr !== 16'h0000 || esc_pending !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: instr=%h esc_pending=%b, expected 0000/0", instr, esc_pending);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hold();
    do_reset();
    cyc(1, 8'h77, 0);  chk("hold_load", 16'h7701, 0);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);  chk("hold_after2", 16'h7701, 0);
    cyc(0, 8'h00, 1);  chk("hold_release", 16'h7700, 0);
    cyc(1, 8'h57, 1);  chk("hold_load_tick", 16'h5701, 0);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);  chk("hold_load_tick_2", 16'h5701, 0);
    cyc(0, 8'h00, 1);  chk("hold_load_tick_rel", 16'h5700, 0);
  endtask

  task automatic test_arrow();
    do_reset();
    cyc(1, 8'h1B, 0);  chk("arrow_esc", 16'h0000, 1);
    cyc(1, 8'h5B, 0);  chk("arrow_csi", 16'h0000, 1);
    cyc(1, 8'h43, 0);  chk("arrow_right", 16'h0008, 0);
    cyc(1, 8'h1B, 0);  chk("lone_esc", 16'h0008, 1);
    cyc(0, 8'h00, 1);  chk("lone_esc_t1", 16'h0008, 1);
    cyc(0, 8'h00, 1);  chk("lone_esc_timeout", 16'h0028, 0);
    cyc(0, 8'h00, 0);  chk("cancel_one_cycle", 16'h0008, 0);
  endtask

  task automatic test_esc_timer();
    do_reset();
    cyc(1, 8'h1B, 0);
    cyc(0, 8'h00, 1);  chk("esc_timer_t1", 16'h0000, 1);
    cyc(1, 8'h1B, 1);  chk("esc_restart", 16'h0000, 1);
    cyc(0, 8'h00, 1);  chk("esc_restart_t1", 16'h0000, 1);
    cyc(0, 8'h00, 1);  chk("esc_restart_timeout", 16'h0020, 0);
    cyc(1, 8'h1B, 0);
    cyc(1, 8'h5B, 0);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);  chk("csi_silent_timeout", 16'h0000, 0);
  endtask

  task automatic test_opposite();
    do_reset();
    cyc(1, 8'h77, 0);  chk("opp_up", 16'h7701, 0);
    cyc(1, 8'h73, 0);  chk("opp_down_clears_up", 16'h7302, 0);
    cyc(1, 8'h77, 0);  chk("opp_up_again", 16'h7701, 0);
    cyc(1, 8'h64, 0);  chk("orth_right", 16'h6409, 0);
    cyc(1, 8'h61, 0);  chk("opp_left_clears_right", 16'h6105, 0);
  endtask

  task automatic test_esc_plain();
    do_reset();
    cyc(1, 8'h1B, 0);
    cyc(1, 8'h71, 0);  chk("esc_q_plain", 16'h7100, 0);
    cyc(1, 8'h1B, 0);
    cyc(1, 8'h5B, 0);
    cyc(1, 8'h5A, 0);  chk("csi_z_discard", 16'h7100, 0);
    cyc(1, 8'h1B, 0);
    cyc(1, 8'h77, 0);  chk("esc_w_plain", 16'h7701, 0);
  endtask

  task automatic test_menu();
    do_reset();
    cyc(1, 8'h33, 0);  chk("menu_3", 16'h3380, 0);
    cyc(1, 8'h20, 0);  chk("confirm_space", 16'h2090, 0);
    cyc(0, 8'h00, 0);  chk("confirm_one_cycle", 16'h2080, 0);
    cyc(1, 8'h39, 0);  chk("menu_9_ignored", 16'h3980, 0);
    cyc(1, 8'h0D, 0);  chk("confirm_cr", 16'h0D90, 0);
    cyc(1, 8'h34, 0);  chk("menu_4", 16'h34C0, 0);
    cyc(1, 8'h31, 0);  chk("menu_1", 16'h3100, 0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(1, 8'h77, 0);
    cyc(1, 8'h64, 0);  chk("b2b_w_d", 16'h6409, 0);
    cyc(1, 8'h33, 0);
    cyc(1, 8'h58, 0);  chk("b2b_cancel", 16'h58A9, 0);
    cyc(0, 8'h00, 0);  chk("b2b_cancel_drop", 16'h5889, 0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(1, 8'h1B, 0);
    cyc(1, 8'h5B, 0);  chk("mid_in_csi", 16'h0000, 1);
    reset = 1'b1;
    #1;
    tests++;
    if (instr !== 16'h0000 || esc_pending !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: instr=%h esc_pending=%b, expected 0000/0", instr, esc_pending);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cyc(1, 8'h41, 0);  chk("after_reset_A", 16'h4104, 0);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tick     = 1'b0;
    @(negedge clk);
    test_reset();
    test_hold();
    test_arrow();
    test_esc_timer();
    test_opposite();
    test_esc_plain();
    test_menu();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_key_decoder.md
# uart_key_decoder

Converts the byte stream delivered by the UART receiver into the 16-bit player instruction word consumed by the game state machine. Sits between the UART receive path and the game controller. It turns discrete terminal keystrokes, including ANSI arrow-key escape sequences, into held direction bits, one-cycle confirm/cancel pulses and a latched menu selection. Hold and escape timing run from the game's slow tick enable, so a terminal's key auto-repeat reads as a continuous press.

## Interface
Parameters:
- HOLD_TICKS, 3: ticks a direction bit stays asserted after its last keypress; legal range 1..255.
- ESC_TIMEOUT, 2: ticks allowed inside an unfinished escape sequence before it is abandoned; legal range 1..255.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- rx_data  in  8  received byte; valid only while rx_valid=1.
- rx_valid  in  1  single-cycle strobe, one per received byte.
- tick  in  1  single-cycle enable from the 10 Hz game tick.
- instr  out  16  [0] up, [1] down, [2] left, [3] right, [4] confirm, [5] cancel, [7:6] menu_sel, [15:8] last_key.
- esc_pending  out  1  high while the escape FSM is not in IDLE.

## Operation
- All outputs are registered. Reset value of instr is 16'h0000 and of esc_pending is 0. All hold counters and the escape timer reset to 0, and the FSM resets to IDLE.
- Plain key map (IDLE, rx_valid=1):
  - up: 'w'/'W'
  - down: 's'/'S'
  - left: 'a'/'A'
  - right: 'd'/'D'
  - confirm: space 0x20 or CR 0x0D
  - cancel: 'x'/'X'
  - menu_sel: '1'..'4' load 0..3
  - ESC 0x1B enters state ESC.
  - Every other byte is ignored.
- last_key loads every byte that is decoded as a plain key, including ignored bytes. It does not load bytes consumed by the escape FSM (ESC, '[', final byte).
- Direction hold uses one 8-bit counter per direction.
  - A key for that direction loads the counter with HOLD_TICKS.
  - The counter decrements by 1 on tick while it is nonzero. It never wraps below 0.
  - The direction bit equals (counter != 0).
  - A key for a direction clears the counter of the opposite direction in the same cycle (up↔down, left↔right). The orthogonal axis is untouched.
  - When a load and a tick occur in the same cycle, the load wins.
- Confirm and cancel are pulses: high for exactly one clk cycle, the cycle after the causing event. Otherwise 0.
- Escape FSM states are IDLE, ESC and CSI.
  - IDLE→ESC on byte 0x1B.
  - In ESC:
    - '[' moves to CSI.
    - 0x1B stays in ESC and restarts the timer.
    - Any other byte returns to IDLE, and that byte is decoded in the same cycle as a plain key.
  - In CSI:
    - 'A'/'B'/'C'/'D' load up/down/right/left respectively, then return to IDLE.
    - Any other byte returns to IDLE and is discarded.
  - Timeout: the escape timer clears on entry to ESC and increments on tick while in ESC or CSI. It uses the same load-wins-over-tick rule as the hold counters: a byte arriving in the same cycle as a tick is processed and the tick is not counted.
    - Timeout in ESC (lone ESC keypress) returns to IDLE and emits a cancel pulse.
    - Timeout in CSI returns to IDLE silently.
- esc_pending = (state != IDLE).
- menu_sel holds its value until the next '1'..'4' or reset.

## Timing
- Latency: rx_valid at edge n gives the updated instr on edge n+1 (1 cycle).
- Direction release: the bit falls on the edge after the HOLD_TICKS-th tick that follows the last load. Ticks in the load cycle do not count.
- Back-to-back rx_valid on consecutive cycles must each be processed; no byte may be dropped.
- A reset assertion mid-sequence (e.g., in CSI) forces IDLE and all-zero outputs immediately. After release, the first byte is decoded from IDLE.
- tick and rx_valid in the same cycle: the byte is processed and the tick also decrements all counters that were not loaded that cycle.

## Test plan
- Reset, then send 'w' → instr[0]=1 one cycle later and last_key=0x77. After 3 ticks with no further bytes, instr[0]=0 on the edge after the third tick.
- Send ESC,'[','C' on consecutive cycles → esc_pending=1 for 2 cycles, then instr[3]=1 and last_key unchanged. Send ESC then 2 ticks → cancel pulse for exactly 1 cycle and esc_pending=0.
- Send 'w' then 's' → instr[0] clears and instr[1] sets in the same cycle. Send 'd' while up is held → up and right both 1.
- Send ESC,'q' → IDLE, with 'q' decoded as a plain byte: last_key=0x71 and no direction set. Send ESC,'[','Z' → discarded, no outputs change.
- Send '3', then space → menu_sel=2 persistent. Confirm is high exactly 1 cycle. Send '9' → menu_sel stays 2 and last_key=0x39.
- Assert reset after ESC,'[' and before the final byte, then release and send 'A' → instr shows last_key=0x41 only, no up bit, esc_pending=0.
